// File: rtl/divider_32_seq.sv
`default_nettype none
// ============================================================================
// Module      : divider_32_seq
// Description : Sequential unsigned restoring divider. One quotient bit per
//               cycle, MSB first; divide-by-zero short-circuits to a saturated
//               quotient and flags div_by_zero.
// Revision    : 1.0 - initial release
// ============================================================================
module divider_32_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int              c_CW       = $clog2(WIDTH);
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(WIDTH - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic             r_go;          // operands captured, dispatch pending
    logic [c_CW-1:0]  r_count;
    logic [WIDTH:0]   r_prem;        // partial remainder
    logic [WIDTH-1:0] r_dvd;         // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dbz;

    logic             w_accept;
    logic             w_last;
    logic             w_dvs_zero;
    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_diff;
    logic             w_borrow;
    logic [WIDTH:0]   w_prem_step;
    logic [WIDTH-1:0] w_dvd_step;

    // A new request is taken whenever no division is running or pending.
    assign w_accept   = start && !r_go && (r_state != c_RUN);
    assign w_last     = (r_count == c_CNT_LAST);
    assign w_dvs_zero = (r_dvs == '0);

    // One restoring step: shift, trial-subtract, restore on borrow.
    assign w_shift     = {r_prem, r_dvd[WIDTH-1]};
    assign w_diff      = w_shift - {2'b00, r_dvs};
    assign w_borrow    = w_diff[WIDTH+1];
    assign w_prem_step = w_borrow ? w_shift[WIDTH:0] : w_diff[WIDTH:0];
    assign w_dvd_step  = {r_dvd[WIDTH-2:0], ~w_borrow};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a start accepted in DONE returns to IDLE with the
    // dispatch pending, so the new operation is already underway.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (r_go) begin
                    w_state_next = w_dvs_zero ? c_DONE : c_RUN;
                end
            end
            c_RUN: begin
                if (w_last) begin
                    w_state_next = c_DONE;
                end
            end
            c_DONE: begin
                w_state_next = c_IDLE;
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    // Operand capture and iteration datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_go    <= 1'b0;
            r_count <= '0;
            r_prem  <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
        end else begin
            r_go <= w_accept;
            if (w_accept) begin
                r_dvd   <= dividend;
                r_dvs   <= divisor;
                r_prem  <= '0;
                r_count <= '0;
            end else if (r_state == c_RUN) begin
                r_prem  <= w_prem_step;
                r_dvd   <= w_dvd_step;
                r_count <= r_count + c_CNT_ONE;
            end
        end
    end

    // Result registers load only on entry to DONE and hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else if ((r_state == c_IDLE) && r_go && w_dvs_zero) begin
            r_quotient  <= '1;
            r_remainder <= r_dvd;
            r_dbz       <= 1'b1;
        end else if ((r_state == c_RUN) && w_last) begin
            r_quotient  <= w_dvd_step;
            r_remainder <= w_prem_step[WIDTH-1:0];
            r_dbz       <= 1'b0;
        end
    end

    assign busy        = (r_state == c_RUN);
    assign done        = (r_state == c_DONE);
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_divider_32_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_divider_32_seq
// Description : Self-checking bench for divider_32_seq; vector table plus
//               hand-written corner sequences, results checked via a queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_divider_32_seq;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    vec_t exp_q[$];
    vec_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_done  = 0;

    divider_32_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t model(input logic [31:0] a, input logic [31:0] b);
        vec_t v;
        v.a = a;
        v.b = b;
        if (b == 0) begin
            v.q = 32'hFFFF_FFFF; v.r = a; v.dz = 1'b1;
        end else begin
            v.q = a / b; v.r = a % b; v.dz = 1'b0;
        end
        return v;
    endfunction

    // Scoreboard: every done pulse pops one expected result.
    always @(posedge clk) begin
        #1;
        if (done === 1'b1) begin
            n_done++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'(done), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("quotient", 64'(quotient), 64'(mon_e.q));
                check("remainder", 64'(remainder), 64'(mon_e.r));
                check("div_by_zero", 64'(div_by_zero), 64'(mon_e.dz));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one start (sampled at the next edge, E0), then scramble operands.
    task automatic start_op(input vec_t v);
        exp_q.push_back(v);
        start    = 1'b1;
        dividend = v.a;
        divisor  = v.b;
        step();
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    task automatic wait_done(input int max, output int cyc, output int bcnt);
        cyc  = 0;
        bcnt = 0;
        while (done !== 1'b1 && cyc < max) begin
            if (busy === 1'b1) bcnt++;
            step();
            cyc++;
        end
        check("done_seen", 64'(done), 64'd1);
    endtask

    task automatic run_and_check(input vec_t v);
        int cyc, bc;
        start_op(v);
        wait_done(40, cyc, bc);
        check("latency", 64'(cyc), (v.b == 0) ? 64'd1 : 64'd33);
        check("busy_cycles", 64'(bc), (v.b == 0) ? 64'd0 : 64'd32);
        repeat (3) step();
        check("held_quotient", 64'(quotient), 64'(v.q));
        check("held_remainder", 64'(remainder), 64'(v.r));
        check("done_low_idle", 64'(done), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[11];
        vec_t v;
        int   cyc, bc, nd0;

        tbl[0]  = '{32'd100,        32'd7,          32'd14,         32'd2,  1'b0};
        tbl[1]  = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,  1'b0};
        tbl[2]  = '{32'd3,          32'hFFFF_FFFF,  32'd0,          32'd3,  1'b0};
        tbl[3]  = '{32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,  1'b1};
        tbl[4]  = '{32'd0,          32'd9,          32'd0,          32'd0,  1'b0};
        tbl[5]  = '{32'd7,          32'd7,          32'd1,          32'd0,  1'b0};
        tbl[6]  = '{32'd6,          32'd7,          32'd0,          32'd6,  1'b0};
        tbl[7]  = '{32'h8000_0000,  32'd3,          32'h2AAA_AAAA,  32'd2,  1'b0};
        tbl[8]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,  1'b0};
        tbl[9]  = '{32'hDEAD_BEEF,  32'h10,         32'h0DEA_DBEE,  32'hF,  1'b0};
        tbl[10] = '{32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0,  1'b1};

        // Asynchronous reset: outputs clear before any clock edge.
        #2;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_quotient", 64'(quotient), 64'd0);
        check("rst_remainder", 64'(remainder), 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 11; i++) begin
            run_and_check(tbl[i]);
        end
        for (int i = 0; i < 4; i++) begin
            v = model($urandom, (i < 2) ? 32'($urandom_range(1, 1000)) : $urandom);
            run_and_check(v);
        end

        // Start pulsed mid-run is ignored.
        nd0 = n_done;
        start_op(tbl[0]);
        repeat (9) step();
        start = 1'b1; dividend = 32'd9; divisor = 32'd2;
        step();
        start = 1'b0;
        wait_done(40, cyc, bc);
        check("ignored_start_latency", 64'(cyc + 10), 64'd33);
        repeat (40) step();
        check("ignored_start_one_done", 64'(n_done), 64'(nd0 + 1));

        // Reset mid-operation aborts with no done pulse.
        start_op(tbl[0]);
        repeat (14) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_outputs_zero", {31'd0, busy, done, quotient, remainder[31:1]} | 64'(remainder[0]) | 64'(div_by_zero), 64'd0);
        exp_q.delete();
        nd0 = n_done;
        repeat (2) step();
        check("abort_busy_in_reset", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) step();
        check("abort_no_done", 64'(n_done), 64'(nd0));
        v = '{32'd50, 32'd5, 32'd10, 32'd0, 1'b0};
        run_and_check(v);

        // Back-to-back: start accepted in the DONE cycle.
        start_op(tbl[0]);
        wait_done(40, cyc, bc);
        check("b2b_first_latency", 64'(cyc), 64'd33);
        v = '{32'd1000, 32'd10, 32'd100, 32'd0, 1'b0};
        start_op(v);
        repeat (16) step();
        check("b2b_held_quotient", 64'(quotient), 64'd14);
        check("b2b_held_remainder", 64'(remainder), 64'd2);
        check("b2b_busy_mid", 64'(busy), 64'd1);
        wait_done(40, cyc, bc);
        check("b2b_second_latency", 64'(cyc + 16), 64'd33);
        repeat (3) step();
        check("b2b_final_quotient", 64'(quotient), 64'd100);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
